control_unit: RTL and testbench

- Multi-cycle LEGv8 control FSM sitting directly upstream of the datapath.
- Consumes the datapath's instruction register (IR) and latched status flags.
- Each cycle, produces the 36-bit controlWord and the 32-bit constant k the datapath executes.
- Handles fetch, decode, execute and branching for a defined LEGv8 subset; a mem_ready handshake lets memory stall the machine.

---
 rtl/control_pkg.sv | 133 +++++++++++++
 rtl/cond_eval.sv | 38 +++
 rtl/control_unit.sv | 177 +++++++++++++++++
 tb/tb_control_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit: state
// encodings, opcode patterns, ALU function codes, select codes and the
// controlWord field layout.
package control_pkg;

  // FSM states
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_CBTEST = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  localparam state_e RESET_STATE = S_FETCH;

  // Opcode patterns, compared against the top bits of IR
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  // ALU function select {invA, invB, op[2:0]}
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00001;
  localparam logic [4:0] FS_ADD = 5'b00010;
  localparam logic [4:0] FS_XOR = 5'b00011;
  localparam logic [4:0] FS_SUB = 5'b01010;

  // Data bus source
  localparam logic [1:0] DATA_ALU  = 2'd0;
  localparam logic [1:0] DATA_REGB = 2'd1;
  localparam logic [1:0] DATA_PC4  = 2'd2;
  localparam logic [1:0] DATA_MEM  = 2'd3;

  // Address bus source
  localparam logic ADDR_ALU = 1'b0;
  localparam logic ADDR_PC  = 1'b1;

  // PC function and PC input select
  localparam logic [1:0] PCFS_HOLD = 2'd0;
  localparam logic [1:0] PCFS_INC4 = 2'd1;
  localparam logic [1:0] PCFS_REL  = 2'd2;
  localparam logic [1:0] PCFS_LOAD = 2'd3;
  localparam logic       PCSEL_REGA = 1'b0;
  localparam logic       PCSEL_K    = 1'b1;

  localparam logic [1:0] SIZE_64 = 2'b11;

  // controlWord bit positions (LSB of each field)
  localparam int CW_FS_LSB     = 30;
  localparam int CW_SA_LSB     = 25;
  localparam int CW_SB_LSB     = 20;
  localparam int CW_DA_LSB     = 15;
  localparam int CW_WREG       = 14;
  localparam int CW_C0         = 13;
  localparam int CW_MEM_CS     = 12;
  localparam int CW_B_SEL      = 11;
  localparam int CW_MEM_W      = 10;
  localparam int CW_IR_LOAD    = 9;
  localparam int CW_STAT_LOAD  = 8;
  localparam int CW_SIZE_LSB   = 6;
  localparam int CW_ADDR_SEL   = 5;
  localparam int CW_DATA_LSB   = 3;
  localparam int CW_PC_SEL     = 2;
  localparam int CW_PCFS_LSB   = 0;

  // Status flag indices
  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_C = 2;
  localparam int STAT_V = 3;

  // controlWord as a packed struct, MSB first, 36 bits total
  typedef struct packed {
    logic       rsvd;
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic       mem_cs;
    logic       b_sel;
    logic       mem_w;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;

  // Decoded instruction class
  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_ORR, I_ADDS, I_SUBS, I_ADDI, I_SUBI,
    I_LDUR, I_STUR, I_B, I_BCOND, I_BR, I_CBZ, I_CBNZ, I_BAD
  } instr_e;

  // Classify an instruction from its top eleven bits
  function automatic instr_e decode_instr(input logic [10:0] op);
    instr_e r;
    r = I_BAD;
    if      (op == OP_ADD)        r = I_ADD;
    else if (op == OP_SUB)        r = I_SUB;
    else if (op == OP_AND)        r = I_AND;
    else if (op == OP_ORR)        r = I_ORR;
    else if (op == OP_ADDS)       r = I_ADDS;
    else if (op == OP_SUBS)       r = I_SUBS;
    else if (op == OP_LDUR)       r = I_LDUR;
    else if (op == OP_STUR)       r = I_STUR;
    else if (op == OP_BR)         r = I_BR;
    else if (op[10:1] == OP_ADDI) r = I_ADDI;
    else if (op[10:1] == OP_SUBI) r = I_SUBI;
    else if (op[10:5] == OP_B)    r = I_B;
    else if (op[10:3] == OP_BCOND) r = I_BCOND;
    else if (op[10:3] == OP_CBZ)  r = I_CBZ;
    else if (op[10:3] == OP_CBNZ) r = I_CBNZ;
    return r;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Evaluates a LEGv8 branch condition code against the latched flags.
module cond_eval
  import control_pkg::*;
(
  input  logic [3:0] status,
  input  logic [3:0] cond,
  output logic       take
);

  logic z, n, c, v;
  assign z = status[STAT_Z];
  assign n = status[STAT_N];
  assign c = status[STAT_C];
  assign v = status[STAT_V];

  // Condition decode; codes 14 and 15 both mean always
  always_comb begin
    take = 1'b0;
    case (cond)
      4'd0:  take = z;
      4'd1:  take = ~z;
      4'd2:  take = c;
      4'd3:  take = ~c;
      4'd4:  take = n;
      4'd5:  take = ~n;
      4'd6:  take = v;
      4'd7:  take = ~v;
      4'd8:  take = c & ~z;
      4'd9:  take = ~c | z;
      4'd10: take = (n == v);
      4'd11: take = (n != v);
      4'd12: take = ~z & (n == v);
      4'd13: take = z | (n != v);
      default: take = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle LEGv8 control FSM. Outputs are combinational from the
// current state and IR; the state only advances on clock edges.
//
// mem_ready handshake: memory raises mem_ready in the cycle it completes
// the access the control word is requesting. The FSM holds its state
// (and keeps PC/register writes disabled) until it sees mem_ready=1 in
// S_FETCH, LDUR or STUR; in every other situation mem_ready is ignored.
module control_unit
  import control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic [35:0] controlWord,
  output logic [31:0] k,
  output logic        halted
);

  state_e state_q, state_d;
  instr_e instr;
  logic   cond_take;
  logic   cb_take;
  cw_t    cw;
  logic [31:0] k_d;

  logic [4:0] rd, rn, rm;
  assign rd = IR[4:0];
  assign rn = IR[9:5];
  assign rm = IR[20:16];

  assign instr = decode_instr(IR[31:21]);

  // IR[24] separates CBZ (0) from CBNZ (1)
  assign cb_take = IR[24] ? ~status[STAT_Z] : status[STAT_Z];

  cond_eval u_cond_eval (
    .status (status),
    .cond   (IR[3:0]),
    .take   (cond_take)
  );

  // State register with asynchronous reset into the fetch state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_EXEC;
      S_EXEC: begin
        case (instr)
          I_LDUR, I_STUR: if (mem_ready) state_d = S_FETCH;
          I_CBZ, I_CBNZ:  state_d = S_CBTEST;
          I_BAD:          state_d = S_HALT;
          default:        state_d = S_FETCH;
        endcase
      end
      S_CBTEST: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = RESET_STATE;
    endcase
  end

  // Control word and constant for the current state and instruction
  always_comb begin
    cw  = '0;
    k_d = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          cw.size         = SIZE_64;
          cw.mem_cs       = 1'b1;
          cw.add_tri_sel  = ADDR_PC;
          cw.data_tri_sel = DATA_MEM;
          cw.ir_load      = mem_ready;
          cw.pc_fs        = PCFS_HOLD;
        end
        S_EXEC: begin
          cw.size = SIZE_64;
          case (instr)
            I_ADD, I_SUB, I_AND, I_ORR, I_ADDS, I_SUBS: begin
              cw.sa    = rn;
              cw.sb    = rm;
              cw.da    = rd;
              cw.w_reg = 1'b1;
              cw.pc_fs = PCFS_INC4;
              case (instr)
                I_SUB, I_SUBS: begin cw.fs = FS_SUB; cw.c0 = 1'b1; end
                I_AND:         cw.fs = FS_AND;
                I_ORR:         cw.fs = FS_OR;
                default:       cw.fs = FS_ADD;
              endcase
              cw.status_load = (instr == I_ADDS) || (instr == I_SUBS);
            end
            I_ADDI, I_SUBI: begin
              k_d      = {20'd0, IR[21:10]};
              cw.sa    = rn;
              cw.da    = rd;
              cw.b_sel = 1'b1;
              cw.w_reg = 1'b1;
              cw.pc_fs = PCFS_INC4;
              if (instr == I_SUBI) begin
                cw.fs = FS_SUB;
                cw.c0 = 1'b1;
              end else begin
                cw.fs = FS_ADD;
              end
            end
            I_LDUR, I_STUR: begin
              // Address = Rn + simm9; both writes wait on mem_ready
              k_d            = {{23{IR[20]}}, IR[20:12]};
              cw.sa          = rn;
              cw.b_sel       = 1'b1;
              cw.fs          = FS_ADD;
              cw.add_tri_sel = ADDR_ALU;
              cw.mem_cs      = 1'b1;
              cw.pc_fs       = mem_ready ? PCFS_INC4 : PCFS_HOLD;
              if (instr == I_LDUR) begin
                cw.da           = rd;
                cw.data_tri_sel = DATA_MEM;
                cw.w_reg        = mem_ready;
              end else begin
                cw.sb           = rd;
                cw.data_tri_sel = DATA_REGB;
                cw.mem_w        = 1'b1;
              end
            end
            I_B: begin
              k_d       = {{6{IR[25]}}, IR[25:0]};
              cw.pc_sel = PCSEL_K;
              cw.pc_fs  = PCFS_REL;
            end
            I_BCOND: begin
              k_d       = {{13{IR[23]}}, IR[23:5]};
              cw.pc_sel = PCSEL_K;
              cw.pc_fs  = cond_take ? PCFS_REL : PCFS_INC4;
            end
            I_BR: begin
              cw.sa     = rn;
              cw.pc_sel = PCSEL_REGA;
              cw.pc_fs  = PCFS_LOAD;
            end
            I_CBZ, I_CBNZ: begin
              // Pass Rt through the ALU (Rt + 0) so Z reflects Rt == 0
              cw.sa          = rd;
              cw.b_sel       = 1'b1;
              cw.fs          = FS_ADD;
              cw.status_load = 1'b1;
              cw.pc_fs       = PCFS_HOLD;
            end
            default: cw = '0;
          endcase
        end
        S_CBTEST: begin
          k_d       = {{13{IR[23]}}, IR[23:5]};
          cw.size   = SIZE_64;
          cw.pc_sel = PCSEL_K;
          cw.pc_fs  = cb_take ? PCFS_REL : PCFS_INC4;
        end
        default: cw = '0;
      endcase
    end
  end

  // Drive the ports from the decoded word
  always_comb begin
    controlWord = cw;
    k           = k_d;
    halted      = !reset && (state_q == S_HALT);
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios followed by randomized
// instruction streams, every cycle compared against a reference model.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic [3:0]  status;
  logic        mem_ready;
  logic [35:0] controlWord;
  logic [31:0] k;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  logic [68:0] exp_q[$];

  // Model phases and instruction classes
  localparam int P_FETCH = 0, P_EXEC = 1, P_CBTEST = 2, P_HALT = 3;
  localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_ORR = 3, C_ADDS = 4,
                 C_SUBS = 5, C_ADDI = 6, C_SUBI = 7, C_LDUR = 8, C_STUR = 9,
                 C_B = 10, C_BCOND = 11, C_BR = 12, C_CBZ = 13, C_CBNZ = 14,
                 C_BAD = 15;

  int phase = P_FETCH;

  control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .IR          (IR),
    .status      (status),
    .mem_ready   (mem_ready),
    .controlWord (controlWord),
    .k           (k),
    .halted      (halted)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int classify(input logic [31:0] ir);
    case (ir[31:21])
      11'b10001011000: return C_ADD;
      11'b11001011000: return C_SUB;
      11'b10001010000: return C_AND;
      11'b10101010000: return C_ORR;
      11'b10101011000: return C_ADDS;
      11'b11101011000: return C_SUBS;
      11'b11111000010: return C_LDUR;
      11'b11111000000: return C_STUR;
      11'b11010110000: return C_BR;
      default: ;
    endcase
    if (ir[31:22] == 10'b1001000100) return C_ADDI;
    if (ir[31:22] == 10'b1101000100) return C_SUBI;
    if (ir[31:26] == 6'b000101)      return C_B;
    if (ir[31:24] == 8'b01010100)    return C_BCOND;
    if (ir[31:24] == 8'b10110100)    return C_CBZ;
    if (ir[31:24] == 8'b10110101)    return C_CBNZ;
    return C_BAD;
  endfunction

  // ARM-style: cond[3:1] picks a base test, cond[0] inverts it; 111x is always
  function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] st);
    logic z, n, c, v, base;
    z = st[0]; n = st[1]; c = st[2]; v = st[3];
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  task automatic model(input int ph, input logic [31:0] ir, input logic [3:0] st,
                       input logic mr, output logic [35:0] cw, output logic [31:0] kk,
                       output logic h, output int nxt);
    logic [4:0] fs, sa, sb, da;
    logic w, c0, cs, bs, mw, irl, sl, ats, pcs, live;
    logic [1:0] dts, pcfs;
    int cls;
    fs = 0; sa = 0; sb = 0; da = 0; w = 0; c0 = 0; cs = 0; bs = 0; mw = 0;
    irl = 0; sl = 0; ats = 0; pcs = 0; dts = 0; pcfs = 0; live = 1;
    kk = 0; h = 0; nxt = P_FETCH;
    cls = classify(ir);
    case (ph)
      P_FETCH: begin
        cs = 1; ats = 1; dts = 3; irl = mr;
        nxt = mr ? P_EXEC : P_FETCH;
      end
      P_EXEC: begin
        case (cls)
          C_ADD, C_SUB, C_AND, C_ORR, C_ADDS, C_SUBS: begin
            sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0]; w = 1; pcfs = 1;
            if (cls == C_SUB || cls == C_SUBS) begin fs = 5'b01010; c0 = 1; end
            else if (cls == C_AND) fs = 5'b00000;
            else if (cls == C_ORR) fs = 5'b00001;
            else fs = 5'b00010;
            sl = (cls == C_ADDS || cls == C_SUBS);
          end
          C_ADDI, C_SUBI: begin
            kk = int'(ir[21:10]);
            sa = ir[9:5]; da = ir[4:0]; bs = 1; w = 1; pcfs = 1;
            fs = (cls == C_SUBI) ? 5'b01010 : 5'b00010;
            c0 = (cls == C_SUBI);
          end
          C_LDUR, C_STUR: begin
            kk = int'($signed(ir[20:12]));
            sa = ir[9:5]; bs = 1; fs = 5'b00010; cs = 1;
            pcfs = mr ? 2'd1 : 2'd0;
            nxt = mr ? P_FETCH : P_EXEC;
            if (cls == C_LDUR) begin da = ir[4:0]; dts = 3; w = mr; end
            else begin sb = ir[4:0]; dts = 1; mw = 1; end
          end
          C_B: begin kk = int'($signed(ir[25:0])); pcs = 1; pcfs = 2; end
          C_BCOND: begin
            kk = int'($signed(ir[23:5])); pcs = 1;
            pcfs = cond_holds(ir[3:0], st) ? 2'd2 : 2'd1;
          end
          C_BR: begin sa = ir[9:5]; pcfs = 3; end
          C_CBZ, C_CBNZ: begin
            sa = ir[4:0]; bs = 1; fs = 5'b00010; sl = 1; nxt = P_CBTEST;
          end
          default: begin live = 0; nxt = P_HALT; end
        endcase
      end
      P_CBTEST: begin
        kk = int'($signed(ir[23:5])); pcs = 1;
        pcfs = ((cls == C_CBZ) == (st[0] == 1'b1)) ? 2'd2 : 2'd1;
      end
      default: begin live = 0; h = 1; nxt = P_HALT; end
    endcase
    cw = live ? {1'b0, fs, sa, sb, da, w, c0, cs, bs, mw, irl, sl, 2'b11, ats, dts, pcs, pcfs}
              : 36'd0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic [31:0] ir, input logic [3:0] st,
                       input logic mr);
    logic [35:0] ecw;
    logic [31:0] ek;
    logic eh;
    int nxt;
    logic [68:0] e;
    @(negedge clock);
    reset = rst; IR = ir; status = st; mem_ready = mr;
    #1;
    if (rst) begin
      ecw = 0; ek = 0; eh = 0; nxt = P_FETCH;
    end else begin
      model(phase, ir, st, mr, ecw, ek, eh, nxt);
    end
    exp_q.push_back({ecw, ek, eh});
    e = exp_q.pop_front();
    check("controlWord", 64'(controlWord), 64'(e[68:33]));
    check("k", 64'(k), 64'(e[32:1]));
    check("halted", 64'(halted), 64'(e[0]));
    phase = nxt;
  endtask

  function automatic logic [31:0] gen_instr();
    int r;
    logic [31:0] x;
    r = $urandom_range(0, 15);
    x = $urandom;
    case (r)
      0:  return {11'b10001011000, x[20:0]};
      1:  return {11'b11001011000, x[20:0]};
      2:  return {11'b10001010000, x[20:0]};
      3:  return {11'b10101010000, x[20:0]};
      4:  return {11'b10101011000, x[20:0]};
      5:  return {11'b11101011000, x[20:0]};
      6:  return {10'b1001000100, x[21:0]};
      7:  return {10'b1101000100, x[21:0]};
      8:  return {11'b11111000010, x[20:0]};
      9:  return {11'b11111000000, x[20:0]};
      10: return {6'b000101, x[25:0]};
      11: return {8'b01010100, x[23:0]};
      12: return {11'b11010110000, x[20:0]};
      13: return {8'b10110100, x[23:0]};
      14: return {8'b10110101, x[23:0]};
      default: return {8'h00, x[23:0]};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ins;
    int halt_cnt;
    reset = 1'b1; IR = 0; status = 0; mem_ready = 0;

    // Reset holds everything at zero
    cycle(1, 32'h0, 4'h0, 1'b0);
    cycle(1, 32'hFFFF_FFFF, 4'hF, 1'b1);

    // ADD X3, X1, X2
    ins = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3};
    cycle(0, ins, 4'h0, 1'b1);
    check("fetch_word", 64'(controlWord), 64'h12F8);
    cycle(0, ins, 4'h0, 1'b1);
    check("add_word", 64'(controlWord), 64'h8221_C0C1);

    // LDUR X5, [X2, #-8] with three stall cycles
    ins = {11'b11111000010, 9'h1F8, 2'b00, 5'd2, 5'd5};
    cycle(0, ins, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, ins, 4'h0, 1'b0);
      check("ldur_k", 64'(k), 64'hFFFF_FFF8);
    end
    cycle(0, ins, 4'h0, 1'b1);

    // B.EQ +4, taken then not taken
    ins = {8'b01010100, 19'd4, 1'b0, 4'd0};
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'b0001, 1'b0);
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'b0000, 1'b0);

    // B.GT: N=1,V=1,Z=0 taken; N=1,V=0 not taken
    ins = {8'b01010100, 19'h7FFFE, 1'b0, 4'd12};
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'b1010, 1'b0);
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'b0010, 1'b0);

    // CBNZ X7: Z=0 taken, Z=1 not taken
    ins = {8'b10110101, 19'd4, 5'd7};
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'b0000, 1'b1);
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'h0, 1'b1);
    cycle(0, ins, 4'b0001, 1'b1);

    // IR=0 halts; reset mid-halt returns to fetch
    cycle(0, 32'h0, 4'h0, 1'b1);
    cycle(0, 32'h0, 4'h0, 1'b1);
    cycle(0, 32'h0, 4'h0, 1'b1);
    cycle(0, 32'h0, 4'h0, 1'b1);
    cycle(1, 32'h0, 4'h0, 1'b1);
    cycle(0, 32'h0, 4'h0, 1'b0);

    // Randomized instruction stream
    ins = gen_instr();
    halt_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (phase == P_HALT) begin
        halt_cnt++;
        if (halt_cnt > 2) begin
          cycle(1, ins, 4'(($urandom)), 1'b0);
          halt_cnt = 0;
          continue;
        end
      end
      if (phase == P_FETCH) ins = gen_instr();
      cycle(0, ins, 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
